reaction_timer_ctrl: RTL and testbench
======================================

# reaction_timer_ctrl

Sequencing controller for the reaction-time game. It waits for a start press, runs a pseudo-random hold-off, lights the stimulus LED and counts elapsed milliseconds in a 4-digit BCD decade chain until the react press. It then freezes the result for the seven-segment decoders. It owns the ms prescaler, the decade-counter enables and clears, and false-start and overflow detection, and sits between the debounced pushbuttons and the BCD-to-7-segment decoders.

## Interface
Parameters:
- TICK_DIV, 50000: clk cycles per 1 ms tick; legal range 2..2^20.
- MIN_DELAY_MS, 1000: fixed part of the hold-off, in ms; 16-bit.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous and active-low; the block has one clock, and reset is synchronous, active-low.
- start_btn  in  1  debounced, synchronized start level; only its rising edge is used.
- react_btn  in  1  debounced, synchronized react level; only its rising edge is used.
- stim_led  out  1  stimulus light; high only in TIMING.
- digits  out  16  four BCD digits, [15:12] = thousands; holds the live count in TIMING and the frozen result in DONE.
- digits_valid  out  1  high in DONE; this is the decoder enable.
- false_start  out  1  high in FAULT.
- overflow  out  1  high in DONE when the count saturated.
- busy  out  1  high in ARM or TIMING.

## Operation
- Edge detect: each button is registered once (prev). rise = btn & ~prev.
- LFSR: 16-bit Fibonacci register, taps 16,14,13,11, seed 16'hACE1 at reset. It advances every cycle in every state.
- FSM states: IDLE, ARM, TIMING, DONE, FAULT.
- IDLE:
  - start rise -> ARM.
  - On the transition, delay_ms = MIN_DELAY_MS + lfsr[9:0], which gives 0..1023 extra ms.
- ARM:
  - The prescaler runs; delay_ms decrements on each tick.
  - react rise -> FAULT.
  - A tick while delay_ms == 1 -> TIMING; digits cleared to 0000 on the same edge.
- TIMING:
  - Each tick increments the BCD chain. Each digit wraps 9 -> 0 with a carry into the next digit.
  - react rise -> DONE; digits freeze.
  - A tick while digits == 9999 -> DONE with overflow = 1; digits stay 9999.
- DONE: start rise -> ARM with a new delay. digits_valid, overflow and digits clear on entry to ARM.
- FAULT: start rise -> ARM. false_start clears on the transition.
- react rises in IDLE, DONE and FAULT are ignored.
- start rises in ARM and TIMING are ignored.
- Simultaneous events:
  - react rise and the final ARM tick in the same cycle -> FAULT. React has priority.
  - react rise and a tick in the same cycle in TIMING -> DONE with the pre-increment value; that tick is dropped.
- Prescaler: counts 0..TICK_DIV-1, and tick is high for one cycle at TICK_DIV-1. It is forced to 0 on every entry to ARM and to TIMING.
- Reset mid-round: all state is lost; return to IDLE with reset values.

## Timing
- Reset values:
  - stim_led, digits_valid, false_start, overflow, busy = 0.
  - digits = 16'h0000; FSM in IDLE.
- Button latency: a button first sampled high at edge N (prev low) produces the state change at edge N+1. All outputs are registered.
- ARM duration: exactly delay_ms × TICK_DIV cycles from ARM entry to stim_led high.
- First TIMING increment: TICK_DIV cycles after TIMING entry.

## Configuration
- REACTION_BEST_EN defined:
  - Adds output best_digits [15:0], reset to 16'h9999.
  - On each entry to DONE with overflow = 0 and digits < best_digits (BCD compare, equal to a binary compare), best_digits <= digits one cycle later.
  - FAULT and overflow results never update it.
- REACTION_BEST_EN undefined: no port and no register.

## Structure
- Package reaction_pkg holds:
  - the state enum;
  - a 4-bit BCD digit typedef;
  - constants LFSR_SEED = 16'hACE1 and LFSR_TAPS;
  - the DIGIT_MAX = 4'd9 constant.
- Sub-module bcd_digit: one decade counter.
  - Inputs: clk, rst_n, clr, inc.
  - Outputs: q[3:0] and carry, where carry = inc & (q == 9).
  - It is instantiated four times, rippling carry into the next digit's inc.
- The FSM, prescaler, LFSR and edge detect live in the top module.

## Test plan
Bench uses TICK_DIV = 4 and MIN_DELAY_MS = 2.
- Reset held 3 cycles, then released -> all outputs 0, digits 0000, best_digits 9999 (macro on).
- start rise, then react 37 ticks after stim_led rises -> DONE, digits 16'h0037, digits_valid = 1, overflow = 0, best_digits 0037.
- Count up to 0009 then 0010, and 0099 then 0100 -> carry ripple verified digit by digit.
- react rise during ARM -> FAULT, false_start = 1, stim_led never set; start rise -> ARM, false_start = 0.
- No react for 10000 ticks -> DONE, digits 9999, overflow = 1, best_digits unchanged.
- react rise coincident with the final ARM tick -> FAULT. react coincident with a TIMING tick at 0041 -> result 0041.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game controller.
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_TIMING,
        ST_DONE,
        ST_FAULT
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam bcd_t        DIGIT_MAX = 4'd9;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reaction_timer_ctrl_bcd_digit.sv
// One decade (0..9) counter of the elapsed-ms BCD chain; carry fires on the 9 -> 0 step.
module bcd_digit
    import reaction_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output bcd_t q,
    output logic carry
);

    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q == DIGIT_MAX) ? bcd_t'(0) : q + bcd_t'(1);
        end
    end

    assign carry = inc & (q == DIGIT_MAX);

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game sequencer: hold-off, stimulus, BCD ms count, freeze of result.
// Optional REACTION_BEST_EN adds a best-result register and best_digits output.
module reaction_timer_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 50000,
    parameter logic [15:0] MIN_DELAY_MS = 16'd1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_btn,
    input  logic        react_btn,
    output logic        stim_led,
    output logic [15:0] digits,
    output logic        digits_valid,
    output logic        false_start,
    output logic        overflow,
    output logic        busy
`ifdef REACTION_BEST_EN
    ,
    output logic [15:0] best_digits
`endif
);

    localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_e        state_q, state_d;
    logic [16:0]   delay_q, delay_d;
    logic [PW-1:0] presc_q;
    logic [15:0]   lfsr_q;
    logic          start_prev, react_prev, start_rise, react_rise;
    logic          overflow_q, ovf_set;
    logic          tick, enter_run, run_inc;
    logic          c0, c1, c2, c3;
    bcd_t          d0, d1, d2, d3;
    logic [15:0]   count;

    assign tick = (presc_q == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            delay_q    <= '0;
            presc_q    <= '0;
            lfsr_q     <= LFSR_SEED;
            start_prev <= 1'b0;
            react_prev <= 1'b0;
            start_rise <= 1'b0;
            react_rise <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            lfsr_q     <= lfsr_next(lfsr_q);
            start_prev <= start_btn;
            react_prev <= react_btn;
            // Registered edge pulses give the one-cycle button-to-state latency.
            start_rise <= start_btn & ~start_prev;
            react_rise <= react_btn & ~react_prev;
            presc_q    <= (enter_run || tick) ? '0 : presc_q + PW'(1);
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (enter_run) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // React on the same cycle as a tick wins: the tick is not counted.
    assign run_inc   = (state_q == ST_TIMING) && tick && !react_rise;
    assign enter_run = (state_d != state_q) && (state_d == ST_ARM || state_d == ST_TIMING);

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_d = state_q;
        delay_d = delay_q;
        ovf_set = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                if (start_rise) begin
                    state_d = ST_ARM;
                    delay_d = {1'b0, MIN_DELAY_MS} + {7'd0, lfsr_q[9:0]};
                end
            end
            ST_ARM: begin
                if (react_rise) begin
                    state_d = ST_FAULT;
                end else if (tick) begin
                    if (delay_q <= 17'd1) begin
                        state_d = ST_TIMING;
                    end else begin
                        delay_d = delay_q - 17'd1;
                    end
                end
            end
            ST_TIMING: begin
                if (react_rise) begin
                    state_d = ST_DONE;
                end else if (c3) begin
                    state_d = ST_DONE;
                    ovf_set = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    bcd_digit u_ones      (.clk(clk), .rst_n(rst_n), .clr(enter_run), .inc(run_inc), .q(d0), .carry(c0));
    bcd_digit u_tens      (.clk(clk), .rst_n(rst_n), .clr(enter_run), .inc(c0),      .q(d1), .carry(c1));
    bcd_digit u_hundreds  (.clk(clk), .rst_n(rst_n), .clr(enter_run), .inc(c1),      .q(d2), .carry(c2));
    bcd_digit u_thousands (.clk(clk), .rst_n(rst_n), .clr(enter_run), .inc(c2),      .q(d3), .carry(c3));

    assign count = {d3, d2, d1, d0};

    // A carry out of the thousands digit is the saturation event; the chain wraps
    // to 0000 on that edge, so the frozen display is forced to 9999 instead.
    assign digits       = overflow_q ? 16'h9999 : count;
    assign stim_led     = (state_q == ST_TIMING);
    assign digits_valid = (state_q == ST_DONE);
    assign false_start  = (state_q == ST_FAULT);
    assign overflow     = overflow_q;
    assign busy         = (state_q == ST_ARM) || (state_q == ST_TIMING);

`ifdef REACTION_BEST_EN
    logic best_chk_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_chk_q  <= 1'b0;
            best_digits <= 16'h9999;
        end else begin
            best_chk_q <= (state_d == ST_DONE) && (state_q != ST_DONE) && !ovf_set;
            // BCD digits order the same way as binary, so a plain compare suffices.
            if (best_chk_q && (count < best_digits)) begin
                best_digits <= count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl (TICK_DIV = 4, MIN_DELAY_MS = 2).
module tb_reaction_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_btn = 1'b0;
    logic        react_btn = 1'b0;
    logic        stim_led, digits_valid, false_start, overflow, busy;
    logic [15:0] digits;
`ifdef REACTION_BEST_EN
    logic [15:0] best_digits;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference LFSR; m_prev is the value that was current before the last edge.
    logic [15:0] m, m_prev;

    reaction_timer_ctrl #(.TICK_DIV(4), .MIN_DELAY_MS(16'd2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_btn    (start_btn),
        .react_btn    (react_btn),
        .stim_led     (stim_led),
        .digits       (digits),
        .digits_valid (digits_valid),
        .false_start  (false_start),
        .overflow     (overflow),
        .busy         (busy)
`ifdef REACTION_BEST_EN
        ,
        .best_digits  (best_digits)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) begin
            m      <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m;
            m      <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
        end
    end

    // Press start; the block must go busy exactly one edge after the press is sampled.
    task automatic start_round(output int d);
        logic b_early;
        start_btn = 1'b1;
        @(negedge clk);
        b_early = busy;
        @(negedge clk);
        start_btn = 1'b0;
        d = 2 + int'(m_prev[9:0]);
        n_checks++;
        if (b_early !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_latency: busy %b then %b, want 0 then 1", b_early, busy);
        end
    endtask

    task automatic wait_stim(input int d);
        int cnt = 0;
        while (stim_led !== 1'b1 && cnt < 4200) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (cnt != d * 4) begin
            n_fail++;
            $display("FAIL arm_duration: %0d cycles, want %0d", cnt, d * 4);
        end
        n_checks++;
        if (digits !== 16'h0000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timing_entry: digits %h busy %b, want 0000 1", digits, busy);
        end
    endtask

    task automatic react_done(input int n, output int lat);
        repeat (n) @(negedge clk);
        react_btn = 1'b1;
        lat = 0;
        while (digits_valid !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        react_btn = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({stim_led, digits_valid, false_start, overflow, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: %b, want 00000",
                     {stim_led, digits_valid, false_start, overflow, busy});
        end
        n_checks++;
        if (digits !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_digits: %h, want 0000", digits);
        end
`ifdef REACTION_BEST_EN
        n_checks++;
        if (best_digits !== 16'h9999) begin
            n_fail++;
            $display("FAIL reset_best: %h, want 9999", best_digits);
        end
`endif
    endtask

    task automatic test_basic_round();
        int d, lat;
        start_round(d);
        wait_stim(d);
        react_done(4 * 37 - 1, lat);
        n_checks++;
        if (lat != 2) begin
            n_fail++;
            $display("FAIL react_latency: %0d cycles, want 2", lat);
        end
        n_checks++;
        if (digits !== 16'h0037) begin
            n_fail++;
            $display("FAIL result_37: %h, want 0037", digits);
        end
        n_checks++;
        if ({digits_valid, overflow, stim_led, busy, false_start} !== 5'b10000) begin
            n_fail++;
            $display("FAIL done_flags: %b, want 10000",
                     {digits_valid, overflow, stim_led, busy, false_start});
        end
        @(negedge clk);
`ifdef REACTION_BEST_EN
        n_checks++;
        if (best_digits !== 16'h0037) begin
            n_fail++;
            $display("FAIL best_update: %h, want 0037", best_digits);
        end
`endif
    endtask

    task automatic test_carry();
        int d, lat;
        int          steps [4] = '{36, 4, 356, 4};
        logic [15:0] want  [4] = '{16'h0009, 16'h0010, 16'h0099, 16'h0100};
        start_round(d);
        n_checks++;
        if (digits !== 16'h0000 || digits_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL arm_clear: digits %h valid %b ovf %b, want 0000 0 0",
                     digits, digits_valid, overflow);
        end
        wait_stim(d);
        for (int i = 0; i < 4; i++) begin
            repeat (steps[i]) @(negedge clk);
            n_checks++;
            if (digits !== want[i]) begin
                n_fail++;
                $display("FAIL carry_%0d: %h, want %h", i, digits, want[i]);
            end
        end
        react_done(0, lat);
        n_checks++;
        if (digits !== 16'h0100 || digits_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL result_100: %h valid %b, want 0100 1", digits, digits_valid);
        end
        @(negedge clk);
`ifdef REACTION_BEST_EN
        n_checks++;
        if (best_digits !== 16'h0037) begin
            n_fail++;
            $display("FAIL best_keep_slower: %h, want 0037", best_digits);
        end
`endif
    endtask

    task automatic test_false_start();
        int d, lat;
        logic stim_seen;
        start_round(d);
        react_btn = 1'b1;
        lat = 0;
        while (false_start !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        react_btn = 1'b0;
        n_checks++;
        if (lat != 2 || {false_start, busy, stim_led, digits_valid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL early_react: lat %0d flags %b, want 2 1000",
                     lat, {false_start, busy, stim_led, digits_valid});
        end
        start_round(d);
        n_checks++;
        if (false_start !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_clear: false_start %b, want 0", false_start);
        end
        // React sampled so that its pulse meets the final hold-off tick.
        stim_seen = 1'b0;
        repeat (4 * d - 2) begin
            @(negedge clk);
            stim_seen |= stim_led;
        end
        react_btn = 1'b1;
        lat = 0;
        while (false_start !== 1'b1 && lat < 8) begin
            @(negedge clk);
            stim_seen |= stim_led;
            lat++;
        end
        react_btn = 1'b0;
        n_checks++;
        if (lat != 2 || false_start !== 1'b1 || stim_seen !== 1'b0 || digits_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL react_on_last_tick: lat %0d fs %b stim_seen %b valid %b, want 2 1 0 0",
                     lat, false_start, stim_seen, digits_valid);
        end
    endtask

    task automatic test_tick_collision();
        int d, lat;
        start_round(d);
        wait_stim(d);
        react_done(4 * 41 + 2, lat);
        n_checks++;
        if (lat != 2 || digits !== 16'h0041) begin
            n_fail++;
            $display("FAIL react_on_tick: lat %0d digits %h, want 2 0041", lat, digits);
        end
        @(negedge clk);
`ifdef REACTION_BEST_EN
        n_checks++;
        if (best_digits !== 16'h0037) begin
            n_fail++;
            $display("FAIL best_keep_41: %h, want 0037", best_digits);
        end
`endif
    endtask

    task automatic test_overflow();
        int d;
        int cnt = 0;
        start_round(d);
        wait_stim(d);
        while (digits_valid !== 1'b1 && cnt < 40100) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (cnt != 40000) begin
            n_fail++;
            $display("FAIL overflow_time: %0d cycles, want 40000", cnt);
        end
        n_checks++;
        if (digits !== 16'h9999 || overflow !== 1'b1 || stim_led !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_result: digits %h ovf %b stim %b, want 9999 1 0",
                     digits, overflow, stim_led);
        end
        @(negedge clk);
`ifdef REACTION_BEST_EN
        n_checks++;
        if (best_digits !== 16'h0037) begin
            n_fail++;
            $display("FAIL best_keep_ovf: %h, want 0037", best_digits);
        end
`endif
        react_btn = 1'b1;
        repeat (4) @(negedge clk);
        react_btn = 1'b0;
        n_checks++;
        if (digits_valid !== 1'b1 || digits !== 16'h9999 || false_start !== 1'b0) begin
            n_fail++;
            $display("FAIL react_in_done: valid %b digits %h fs %b, want 1 9999 0",
                     digits_valid, digits, false_start);
        end
        start_round(d);
        n_checks++;
        if (overflow !== 1'b0 || digits_valid !== 1'b0 || digits !== 16'h0000) begin
            n_fail++;
            $display("FAIL rearm_after_ovf: ovf %b valid %b digits %h, want 0 0 0000",
                     overflow, digits_valid, digits);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (busy !== 1'b0 || digits !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid_round: busy %b digits %h, want 0 0000", busy, digits);
        end
    endtask

    initial begin
        test_reset();
        test_basic_round();
        test_carry();
        test_false_start();
        test_tick_collision();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
